// File: rtl/isa_pkg.sv
// Shared ISA definitions: mnemonic codes, MIPS-I opcode/funct values,
// loader FSM state encoding and field-packing helpers.
package isa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Mnemonic codes presented on in_mnem; anything above MN_J is illegal.
  localparam logic [5:0] MN_NOP  = 6'd0,  MN_ADD  = 6'd1,  MN_ADDU  = 6'd2,  MN_SUB  = 6'd3;
  localparam logic [5:0] MN_SUBU = 6'd4,  MN_AND  = 6'd5,  MN_OR    = 6'd6,  MN_XOR  = 6'd7;
  localparam logic [5:0] MN_NOR  = 6'd8,  MN_SLT  = 6'd9,  MN_SLTU  = 6'd10, MN_SLL  = 6'd11;
  localparam logic [5:0] MN_SRL  = 6'd12, MN_SRA  = 6'd13, MN_SLLV  = 6'd14, MN_SRLV = 6'd15;
  localparam logic [5:0] MN_SRAV = 6'd16, MN_JR   = 6'd17, MN_ADDI  = 6'd18, MN_ADDIU = 6'd19;
  localparam logic [5:0] MN_ANDI = 6'd20, MN_ORI  = 6'd21, MN_XORI  = 6'd22, MN_SLTI = 6'd23;
  localparam logic [5:0] MN_SLTIU = 6'd24, MN_LUI = 6'd25, MN_LW    = 6'd26, MN_LH   = 6'd27;
  localparam logic [5:0] MN_LB   = 6'd28, MN_SW   = 6'd29, MN_BEQ   = 6'd30, MN_BNE  = 6'd31;
  localparam logic [5:0] MN_BGEZ = 6'd32, MN_BGTZ = 6'd33, MN_BLEZ  = 6'd34, MN_BLTZ = 6'd35;
  localparam logic [5:0] MN_J    = 6'd36;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM rt selectors for the compare-with-zero branches
  localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; head word visible on o_dout.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;

  assign o_dout  = r_mem[r_rd];
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);

  // Storage array carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic commands into MIPS-I words, buffers them
// in a small FIFO and streams them into instruction memory.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic        done,
  output logic        err,
  output logic [8:0]  word_count
);
  import isa_pkg::*;

  state_e      r_state, w_state_nxt;
  logic        w_legal;
  logic [31:0] w_word;
  logic        w_accept, w_push, w_pop;
  logic [31:0] w_head;
  logic        w_full, w_empty;
  logic [7:0]  r_addr;
  logic [8:0]  r_wc;
  logic        r_err;

  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && w_legal;
  assign w_pop      = imem_we && imem_ready;

  assign in_ready   = (r_state == ST_LOAD) && !w_full;
  assign imem_we    = !w_empty && (r_state == ST_LOAD || r_state == ST_DRAIN);
  assign imem_wdata = imem_we ? w_head : 32'h0;
  assign imem_addr  = r_addr;
  assign done       = (r_state == ST_DRAIN) && w_empty;
  assign err        = r_err;
  assign word_count = r_wc;

  // Combinational encoder: mnemonic plus fields to a 32-bit instruction word.
  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0;
    case (in_mnem)
      MN_NOP:   w_word = 32'h0;
      MN_ADD:   w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_ADD);
      MN_ADDU:  w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_ADDU);
      MN_SUB:   w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SUB);
      MN_SUBU:  w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SUBU);
      MN_AND:   w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_AND);
      MN_OR:    w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_OR);
      MN_XOR:   w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_XOR);
      MN_NOR:   w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_NOR);
      MN_SLT:   w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SLT);
      MN_SLTU:  w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SLTU);
      MN_SLL:   w_word = pack_r(5'd0, in_rt, in_rd, in_shamt, FN_SLL);
      MN_SRL:   w_word = pack_r(5'd0, in_rt, in_rd, in_shamt, FN_SRL);
      MN_SRA:   w_word = pack_r(5'd0, in_rt, in_rd, in_shamt, FN_SRA);
      MN_SLLV:  w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SLLV);
      MN_SRLV:  w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SRLV);
      MN_SRAV:  w_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SRAV);
      MN_JR:    w_word = pack_r(in_rs, 5'd0, 5'd0, 5'd0, FN_JR);
      MN_ADDI:  w_word = pack_i(OP_ADDI, in_rs, in_rt, in_imm);
      MN_ADDIU: w_word = pack_i(OP_ADDIU, in_rs, in_rt, in_imm);
      MN_ANDI:  w_word = pack_i(OP_ANDI, in_rs, in_rt, in_imm);
      MN_ORI:   w_word = pack_i(OP_ORI, in_rs, in_rt, in_imm);
      MN_XORI:  w_word = pack_i(OP_XORI, in_rs, in_rt, in_imm);
      MN_SLTI:  w_word = pack_i(OP_SLTI, in_rs, in_rt, in_imm);
      MN_SLTIU: w_word = pack_i(OP_SLTIU, in_rs, in_rt, in_imm);
      MN_LUI:   w_word = pack_i(OP_LUI, 5'd0, in_rt, in_imm);
      MN_LW:    w_word = pack_i(OP_LW, in_rs, in_rt, in_imm);
      MN_LH:    w_word = pack_i(OP_LH, in_rs, in_rt, in_imm);
      MN_LB:    w_word = pack_i(OP_LB, in_rs, in_rt, in_imm);
      MN_SW:    w_word = pack_i(OP_SW, in_rs, in_rt, in_imm);
      MN_BEQ:   w_word = pack_i(OP_BEQ, in_rs, in_rt, in_imm);
      MN_BNE:   w_word = pack_i(OP_BNE, in_rs, in_rt, in_imm);
      MN_BGEZ:  w_word = pack_i(OP_REGIMM, in_rs, RT_BGEZ, in_imm);
      MN_BGTZ:  w_word = pack_i(OP_BGTZ, in_rs, 5'd0, in_imm);
      MN_BLEZ:  w_word = pack_i(OP_BLEZ, in_rs, 5'd0, in_imm);
      MN_BLTZ:  w_word = pack_i(OP_REGIMM, in_rs, RT_BLTZ, in_imm);
      MN_J:     w_word = {OP_J, in_target};
      default:  w_legal = 1'b0;
    endcase
  end

  sync_fifo #(.DEPTH(4), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_word),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state: leave DRAIN only once every buffered word is written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_accept && in_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Write address, word counter and sticky illegal-mnemonic flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= 8'h0;
      r_wc   <= 9'h0;
      r_err  <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_addr <= base_addr;
      r_wc   <= 9'h0;
      r_err  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + 8'd1;
        r_wc   <= r_wc + 9'd1;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a field-level reference encoder and
// an expected-write scoreboard checked on every memory write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_mnem = 6'h0;
  logic [4:0]  in_rs = 5'h0, in_rt = 5'h0, in_rd = 5'h0, in_shamt = 5'h0;
  logic [15:0] in_imm = 16'h0;
  logic [25:0] in_target = 26'h0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready = 1'b1;
  logic        done, err;
  logic [8:0]  word_count;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_addr = 8'h0;
  int          exp_wc = 0;
  bit          exp_err = 1'b0;
  int          done_cnt = 0;
  int          acc_cnt = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Reference encoder built directly from the field layout tables.
  function automatic logic [31:0] model_enc(input int mn, input int rs, input int rt, input int rd,
                                            input int sh, input int imm, input int tgt);
    int fn_tab[17] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8};
    int op_tab[14] = '{8, 9, 12, 13, 14, 10, 11, 15, 35, 33, 32, 43, 4, 5};
    longint w;
    w = 0;
    if (mn >= 1 && mn <= 17) begin
      if (mn >= 11 && mn <= 13) rs = 0; else sh = 0;
      if (mn == 17) begin rt = 0; rd = 0; end
      w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + sh * 64'd64 + fn_tab[mn-1];
    end else if (mn >= 18 && mn <= 31) begin
      if (mn == 25) rs = 0;
      w = op_tab[mn-18] * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
    end else if (mn >= 32 && mn <= 35) begin
      case (mn)
        32: begin w = 1; rt = 1; end
        33: begin w = 7; rt = 0; end
        34: begin w = 6; rt = 0; end
        default: begin w = 1; rt = 0; end
      endcase
      w = w * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
    end else if (mn == 36) begin
      w = 2 * 64'd67108864 + tgt;
    end
    return w[31:0];
  endfunction

  task automatic do_start(input logic [7:0] base);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    exp_addr = base; exp_wc = 0; exp_err = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_cmd(input int mn, input int rs, input int rt, input int rd, input int sh,
                          input int imm, input int tgt, input bit last);
    int n = 0;
    in_valid = 1'b1; in_mnem = mn[5:0]; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0];
    in_shamt = sh[4:0]; in_imm = imm[15:0]; in_target = tgt[25:0]; in_last = last;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end else begin
      acc_cnt++;
      if (mn <= 36) exp_q.push_back(model_enc(mn, rs, rt, rd, sh, imm, tgt));
      else exp_err = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check_eq({name, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    check_eq({name, "_word_count"}, 32'(word_count), 32'(exp_wc));
    check_eq({name, "_err"}, 32'(err), 32'(exp_err));
    check_eq({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check_eq({name, "_idle_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({name, "_we"}, 32'(imem_we), 32'd0);
    check_eq({name, "_addr"}, 32'(imem_addr), 32'd0);
    check_eq({name, "_wdata"}, imem_wdata, 32'd0);
    check_eq({name, "_done"}, 32'(done), 32'd0);
    check_eq({name, "_err"}, 32'(err), 32'd0);
    check_eq({name, "_wc"}, 32'(word_count), 32'd0);
  endtask

  // Write monitor: scoreboard compare, stall stability and done sanity.
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        check_eq("done_with_empty_queue", 32'(exp_q.size()), 32'd0);
      end
      if (stall_prev) begin
        check_eq("stall_we_held", 32'(imem_we), 32'd1);
        check_eq("stall_addr_held", 32'(imem_addr), 32'(prev_addr));
        check_eq("stall_data_held", imem_wdata, prev_data);
      end
      if (imem_we && imem_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr 0x%02h data 0x%08h expected no write", imem_addr, imem_wdata);
        end else begin
          check_eq("write_data", imem_wdata, exp_q.pop_front());
          check_eq("write_addr", 32'(imem_addr), 32'(exp_addr));
          exp_addr = exp_addr + 8'd1;
          exp_wc++;
        end
      end
      stall_prev = imem_we && !imem_ready;
      prev_addr  = imem_addr;
      prev_data  = imem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Pin the reference encoder with hand-derived words.
    check_eq("pin_add",  model_enc(1, 1, 2, 3, 0, 0, 0), 32'h00221820);
    check_eq("pin_addi", model_enc(18, 1, 2, 0, 0, 5, 0), 32'h20220005);
    check_eq("pin_sll",  model_enc(11, 7, 2, 4, 3, 0, 0), 32'h000220C0);
    check_eq("pin_bgez", model_enc(32, 5, 9, 0, 0, 16'hFFFE, 0), 32'h04A1FFFE);
    check_eq("pin_lw",   model_enc(26, 29, 8, 0, 0, 4, 0), 32'h8FA80004);
    check_eq("pin_j",    model_enc(36, 0, 0, 0, 0, 0, 26'h100), 32'h08000100);
    check_eq("pin_jr",   model_enc(17, 31, 3, 4, 5, 0, 0), 32'h03E00008);
    check_eq("pin_lui",  model_enc(25, 6, 7, 0, 0, 16'h1234, 0), 32'h3C071234);

    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("reset");

    // Single ADD
    do_start(8'h10);
    send_cmd(1, 1, 2, 3, 0, 0, 0, 1'b1);
    wait_done("add");

    // ADDI then SLL with nonzero rs
    do_start(8'h20);
    send_cmd(18, 1, 2, 0, 0, 5, 0, 1'b0);
    send_cmd(11, 7, 2, 4, 3, 0, 0, 1'b1);
    wait_done("addi_sll");

    // Branch, load, jump
    do_start(8'h30);
    send_cmd(32, 5, 9, 0, 0, 16'hFFFE, 0, 1'b0);
    send_cmd(26, 29, 8, 0, 0, 4, 0, 1'b0);
    send_cmd(36, 0, 0, 0, 0, 0, 26'h100, 1'b1);
    wait_done("br_ld_j");

    // Field-forcing mix
    do_start(8'h50);
    send_cmd(17, 31, 3, 4, 5, 0, 0, 1'b0);
    send_cmd(25, 6, 7, 0, 0, 16'h1234, 0, 1'b0);
    send_cmd(16, 1, 2, 3, 9, 0, 0, 1'b0);
    send_cmd(35, 4, 8, 0, 0, 16'h0010, 0, 1'b0);
    send_cmd(33, 4, 8, 0, 0, 16'h0020, 0, 1'b0);
    send_cmd(34, 4, 8, 0, 0, 16'h0030, 0, 1'b0);
    send_cmd(29, 2, 3, 0, 0, 16'h8000, 0, 1'b1);
    wait_done("mix");

    // Address wrap
    do_start(8'hFE);
    for (int i = 0; i < 3; i++) send_cmd(0, 0, 0, 0, 0, 0, 0, i == 2);
    wait_done("wrap");
    check_eq("wrap_final_addr", 32'(imem_addr), 32'h01);

    // Backpressure: memory stalled for 10 cycles while 6 commands are offered
    imem_ready = 1'b0;
    acc_cnt = 0;
    do_start(8'h40);
    fork
      begin
        for (int i = 0; i < 6; i++) send_cmd(18, i, i + 1, 0, 0, i * 3, 0, i == 5);
      end
      begin
        repeat (10) @(posedge clk);
        #2;
        check_eq("bp_accepted", 32'(acc_cnt), 32'd4);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_we", 32'(imem_we), 32'd1);
        imem_ready = 1'b1;
      end
    join
    wait_done("backpressure");

    // Illegal mnemonic as last command
    do_start(8'h60);
    send_cmd(40, 1, 2, 3, 0, 0, 0, 1'b1);
    wait_done("illegal");
    do_start(8'h70);
    check_eq("err_cleared_on_start", 32'(err), 32'd0);
    send_cmd(5, 1, 2, 3, 0, 0, 0, 1'b1);
    wait_done("after_illegal");

    // Reset in the middle of a stalled load
    imem_ready = 1'b0;
    do_start(8'h80);
    send_cmd(1, 1, 2, 3, 0, 0, 0, 1'b0);
    send_cmd(18, 4, 5, 0, 0, 7, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midload_reset");
    rst = 1'b0;
    exp_q.delete();
    imem_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check_eq("post_reset_we", 32'(imem_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
